ped_request_ctrl: RTL and testbench

//  Pedestrian-request stage directly upstream of the single-light traffic controller.

---
 rtl/ped_pkg.sv | 25 ++
 rtl/ped_debounce.sv | 43 ++++
 rtl/ped_request_ctrl.sv | 136 +++++++++++++
 tb/tb_ped_request_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// rtl/ped_pkg.sv - shared state encoding and controller constants for the pedestrian request stage
package ped_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PENDING = 3'd1,
        WALK    = 3'd2,
        CLEAR   = 3'd3,
        GAP     = 3'd4
    } ped_state_t;

    // Encoding the downstream traffic controller uses for its red state
    localparam logic [1:0] CTRL_RED_STATE = 2'b00;

    // States in which the controller must be held at red
    function automatic logic holds_red(input ped_state_t s);
        return (s == PENDING) || (s == WALK) || (s == CLEAR);
    endfunction

    // States in which the walk lamp may be lit (steady or flashing)
    function automatic logic crossing_active(input ped_state_t s);
        return (s == WALK) || (s == CLEAR);
    endfunction

endpackage

// File: rtl/ped_debounce.sv
// rtl/ped_debounce.sv - button synchroniser plus stable-run debouncer with rise pulse
module ped_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int RUN_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic [RUN_W-1:0] run;
    logic             run_full;

    // run_full means the current sample completes DEBOUNCE_CYCLES consecutive highs
    assign run_full = (run == RUN_W'(DEBOUNCE_CYCLES - 1));

    // Two-flop synchroniser, then count consecutive high samples; any low clears the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            run   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            rise  <= sync2 && !level && run_full;
            level <= sync2 && (level || run_full);
            if (!sync2) begin
                run <= '0;
            end else if (!run_full) begin
                run <= run + RUN_W'(1);
            end
        end
    end

endmodule

// File: rtl/ped_request_ctrl.sv
// rtl/ped_request_ctrl.sv - pedestrian request FSM, phase timing and lamp drive
module ped_request_ctrl
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WALK_CYCLES     = 8,
    parameter int CLEAR_CYCLES    = 4,
    parameter int GAP_CYCLES      = 6,
    parameter int CNT_W           = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic phase_red_i,
    output logic req_o,
    output logic walk_o,
    output logic dont_walk_o,
    output logic pending_o,
    output logic served_o,
    output logic fault_o
);

    ped_state_t       state;
    ped_state_t       state_nx;
    logic [CNT_W-1:0] cnt;
    logic             btn_level;
    logic             btn_rise;
    logic             press;
    logic             red_lost;
    logic             walk_done;
    logic             clear_done;
    logic             gap_done;

    logic req_d;
    logic walk_d;
    logic dont_walk_d;
    logic pending_d;
    logic served_d;
    logic fault_d;

    ped_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .level  (btn_level),
        .rise   (btn_rise)
    );

    // rise is only ever asserted together with level; gating keeps the pair coherent
    assign press      = btn_rise && btn_level;
    assign red_lost   = crossing_active(state) && !phase_red_i;
    assign walk_done  = (cnt == CNT_W'(WALK_CYCLES - 1));
    assign clear_done = (cnt == CNT_W'(CLEAR_CYCLES - 1));
    assign gap_done   = (cnt == CNT_W'(GAP_CYCLES - 1));

    // State, phase counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            req_o       <= 1'b0;
            walk_o      <= 1'b0;
            dont_walk_o <= 1'b1;
            pending_o   <= 1'b0;
            served_o    <= 1'b0;
            fault_o     <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= (state_nx != state) ? '0 : cnt + CNT_W'(1);
            req_o       <= req_d;
            walk_o      <= walk_d;
            dont_walk_o <= dont_walk_d;
            pending_o   <= pending_d;
            served_o    <= served_d;
            fault_o     <= fault_d;
        end
    end

    // Next-state: loss of red during the crossing pre-empts the phase timers
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (pending_o) begin
                    state_nx = PENDING;
                end
            end
            PENDING: begin
                if (phase_red_i) begin
                    state_nx = WALK;
                end
            end
            WALK: begin
                if (red_lost) begin
                    state_nx = GAP;
                end else if (walk_done) begin
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                if (red_lost || clear_done) begin
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_nx = pending_o ? PENDING : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from the next state; flashing starts dark on CLEAR entry
    always_comb begin
        req_d       = holds_red(state_nx);
        dont_walk_d = !crossing_active(state_nx);
        walk_d      = 1'b0;
        if (state_nx == WALK) begin
            walk_d = 1'b1;
        end else if ((state_nx == CLEAR) && (state == CLEAR)) begin
            walk_d = ~walk_o;
        end
        served_d  = (state == CLEAR) && (state_nx == GAP) && !red_lost;
        fault_d   = fault_o || red_lost;
        pending_d = pending_o;
        if (press) begin
            pending_d = 1'b1;
        end else if ((state_nx == WALK) && (state != WALK)) begin
            pending_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// tb/tb_ped_request_ctrl.sv - self-checking bench for ped_request_ctrl
module tb_ped_request_ctrl;

    localparam int D = 4;
    localparam int W = 8;
    localparam int C = 4;
    localparam int G = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b0;
    logic phase_red_i = 1'b0;
    logic req_o;
    logic walk_o;
    logic dont_walk_o;
    logic pending_o;
    logic served_o;
    logic fault_o;

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    ped_request_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .WALK_CYCLES    (W),
        .CLEAR_CYCLES   (C),
        .GAP_CYCLES     (G),
        .CNT_W          (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .phase_red_i(phase_red_i),
        .req_o      (req_o),
        .walk_o     (walk_o),
        .dont_walk_o(dont_walk_o),
        .pending_o  (pending_o),
        .served_o   (served_o),
        .fault_o    (fault_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 waiting for red, 2 walk, 3 clear, 4 gap; el = cycles spent in phase
    logic [D+2:0] hist;      // hist[j] = raw button sampled j+1 edges ago
    int   m_phase, m_el, n_phase, n_el;
    logic m_pend, m_req, m_walk, m_dw, m_served, m_fault;
    logic m_press, n_flt, n_srv;

    always_comb begin
        // debounced level after edge m is "last D synchronised samples high";
        // the press visible now is the rising edge of that level one edge ago
        m_press = (&hist[D+1:2]) && !(&hist[D+2:3]);
        n_phase = m_phase;
        n_flt = 1'b0;
        n_srv = 1'b0;
        if (m_phase == 0) begin
            if (m_pend) n_phase = 1;
        end else if (m_phase == 1) begin
            if (phase_red_i) n_phase = 2;
        end else if (m_phase == 2 || m_phase == 3) begin
            if (!phase_red_i) begin
                n_phase = 4;
                n_flt = 1'b1;
            end else if (m_phase == 2 && m_el == W - 1) begin
                n_phase = 3;
            end else if (m_phase == 3 && m_el == C - 1) begin
                n_phase = 4;
                n_srv = 1'b1;
            end
        end else begin
            if (m_el == G - 1) n_phase = m_pend ? 1 : 0;
        end
        n_el = (n_phase != m_phase) ? 0 : m_el + 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist     <= '0;
            m_phase  <= 0;
            m_el     <= 0;
            m_pend   <= 1'b0;
            m_req    <= 1'b0;
            m_walk   <= 1'b0;
            m_dw     <= 1'b1;
            m_served <= 1'b0;
            m_fault  <= 1'b0;
        end else begin
            hist     <= {hist[D+1:0], btn_raw};
            m_phase  <= n_phase;
            m_el     <= n_el;
            m_pend   <= m_press ? 1'b1 : ((n_phase == 2 && m_phase != 2) ? 1'b0 : m_pend);
            m_req    <= (n_phase >= 1 && n_phase <= 3);
            m_walk   <= (n_phase == 2) || (n_phase == 3 && (n_el % 2) == 1);
            m_dw     <= !(n_phase == 2 || n_phase == 3);
            m_served <= n_srv;
            m_fault  <= m_fault || n_flt;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_req", req_o, m_req);
            chk("model_walk", walk_o, m_walk);
            chk("model_dont_walk", dont_walk_o, m_dw);
            chk("model_pending", pending_o, m_pend);
            chk("model_served", served_o, m_served);
            chk("model_fault", fault_o, m_fault);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_walk(input string name);
        int n;
        n = 0;
        while (walk_o !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk({name, "_walk_timeout"}, walk_o, 1'b1);
    endtask

    task automatic press_btn(input int n);
        btn_raw = 1'b1;
        ticks(n);
        btn_raw = 1'b0;
    endtask

    int served_cnt;

    initial begin
        // Reset
        ticks(2);
        chk("rst_req", req_o, 1'b0);
        chk("rst_walk", walk_o, 1'b0);
        chk("rst_dont_walk", dont_walk_o, 1'b1);
        chk("rst_pending", pending_o, 1'b0);
        rst = 1'b0;
        cmp_en = 1'b1;
        ticks(2);

        // Bounce: 3 high, 1 low, 3 high never yields a press
        for (int i = 0; i < 7; i++) begin
            btn_raw = (i == 3) ? 1'b0 : 1'b1;
            tick();
        end
        btn_raw = 1'b0;
        ticks(10);
        chk("bounce_pending", pending_o, 1'b0);
        chk("bounce_req", req_o, 1'b0);

        // Normal crossing
        phase_red_i = 1'b1;
        btn_raw = 1'b1;
        served_cnt = 0;
        for (int e = 1; e <= 28; e++) begin
            tick();
            if (e == 10) btn_raw = 1'b0;
            if (served_o) served_cnt++;
            if (e == 7) chk("norm_req_e7", req_o, 1'b0);
            if (e == 8) chk("norm_req_e8", req_o, 1'b1);
            if (e == 9) chk("norm_walk_e9", walk_o, 1'b1);
            if (e == 9) chk("norm_pend_clr_e9", pending_o, 1'b0);
            if (e == 16) chk("norm_walk_e16", walk_o, 1'b1);
            if (e == 17) chk("norm_walk_e17", walk_o, 1'b0);
            if (e == 17) chk("norm_dw_e17", dont_walk_o, 1'b0);
            if (e == 18) chk("norm_walk_e18", walk_o, 1'b1);
            if (e == 20) chk("norm_walk_e20", walk_o, 1'b1);
            if (e == 21) chk("norm_served_e21", served_o, 1'b1);
            if (e == 21) chk("norm_req_e21", req_o, 1'b0);
            if (e == 22) chk("norm_served_e22", served_o, 1'b0);
            if (e == 28) chk("norm_req_idle", req_o, 1'b0);
        end
        chk_int("norm_served_count", served_cnt, 1);

        // Wait for red
        phase_red_i = 1'b0;
        press_btn(6);
        ticks(14);
        chk("wait_req", req_o, 1'b1);
        chk("wait_walk", walk_o, 1'b0);
        chk("wait_pending", pending_o, 1'b1);
        phase_red_i = 1'b1;
        tick();
        chk("wait_walk_next", walk_o, 1'b1);
        ticks(W + C + G + 2);

        // Queued press during WALK
        press_btn(6);
        wait_walk("queue");
        press_btn(5);
        begin
            int n;
            n = 0;
            while (served_o !== 1'b1 && n < 30) begin
                tick();
                n++;
            end
            chk("queue_served_timeout", served_o, 1'b1);
        end
        chk("queue_pending_at_served", pending_o, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("queue_gap_req", req_o, 1'b0);
        end
        tick();
        chk("queue_req_after_gap", req_o, 1'b1);
        ticks(W + C + G + 4);

        // Fault: red lost at WALK cycle 3
        press_btn(6);
        wait_walk("fault");
        ticks(3);
        phase_red_i = 1'b0;
        tick();
        chk("fault_walk", walk_o, 1'b0);
        chk("fault_dw", dont_walk_o, 1'b1);
        chk("fault_flag", fault_o, 1'b1);
        chk("fault_served", served_o, 1'b0);
        chk("fault_req", req_o, 1'b0);
        phase_red_i = 1'b1;
        served_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (served_o) served_cnt++;
        end
        chk_int("fault_no_served", served_cnt, 0);
        chk("fault_sticky", fault_o, 1'b1);

        // Asynchronous reset mid-crossing
        press_btn(6);
        wait_walk("arst");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", req_o, 1'b0);
        chk("arst_walk", walk_o, 1'b0);
        chk("arst_dont_walk", dont_walk_o, 1'b1);
        chk("arst_fault", fault_o, 1'b0);
        chk("arst_pending", pending_o, 1'b0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        ticks(4);
        chk("arst_after_req", req_o, 1'b0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
